// File: rtl/ahb_pkg.sv
// Shared AHB definitions: htrans encodings and bridge arbiter state encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_SAT = 8'hFF;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so search starts at rr+1, isolate the
// lowest set bit, rotate the one-hot result back.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr,
    output logic [N-1:0] winner,
    output logic         valid
);

    logic [W-1:0]   start;
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_win;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_win;

    // start may wrap to 0 when N is a power of two, which is still (rr+1) mod N
    assign start   = rr + W'(1);
    assign dbl_req = {req, req} >> start;
    assign rot_req = dbl_req[N-1:0];
    assign rot_win = rot_req & (~rot_req + 1'b1);
    assign dbl_win = {rot_win, rot_win} << start;
    assign winner  = dbl_win[2*N-1:N];
    assign valid   = |req;

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter for the AHB-to-APB bridge slave port, with locked
// sequences, burst protection and a bounded hold time for unlocked owners.
module ahb_bridge_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2,
    parameter int HOLD_MAX    = 16
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [NUM_MASTERS-1:0]   hbusreq,
    input  logic [NUM_MASTERS-1:0]   hlock,
    input  logic [2*NUM_MASTERS-1:0] htrans_m,
    input  logic                     hready,
    output logic [NUM_MASTERS-1:0]   hgrant,
    output logic [MW-1:0]            hmaster,
    output logic                     hmastlock
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    arb_state_e             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [MW-1:0]          rr, rr_nxt;
    logic [MW-1:0]          owner, pick_idx;
    logic [NUM_MASTERS-1:0] grant_nxt, pick;
    logic                   pick_vld;
    logic [1:0]             cur_trans, hm_trans;
    logic                   owner_req, owner_lock, in_burst, rearb;

    rr_priority_pick #(.N(NUM_MASTERS), .W(MW)) u_pick (
        .req    (hbusreq),
        .rr     (rr),
        .winner (pick),
        .valid  (pick_vld)
    );

    always_comb begin
        owner    = '0;
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) owner    = MW'(i);
            if (pick[i])   pick_idx = MW'(i);
        end
    end

    assign cur_trans  = htrans_m[2*owner +: 2];
    assign hm_trans   = htrans_m[2*hmaster +: 2];
    assign owner_req  = hbusreq[owner];
    assign owner_lock = hlock[owner];
    assign in_burst   = (cur_trans == HTRANS_SEQ) || (cur_trans == HTRANS_BUSY);

    // Hold limit only applies to unlocked owners; a locked owner leaves by dropping hlock.
    assign rearb = !in_burst &&
                   (!owner_req ||
                    ((state == ARB_LOCKED) ? !owner_lock : (cnt >= HOLD_LIM)));

    always_comb begin
        grant_nxt = hgrant;
        rr_nxt    = rr;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (rearb) begin
            cnt_nxt = '0;
            if (pick_vld) begin
                grant_nxt = pick;
                rr_nxt    = pick_idx;
                state_nxt = ARB_OWNED;
            end else begin
                grant_nxt = NUM_MASTERS'(1);
                state_nxt = ARB_PARK;
            end
        end else begin
            if ((hm_trans == HTRANS_NONSEQ || hm_trans == HTRANS_SEQ) && cnt != CNT_SAT)
                cnt_nxt = cnt + 1'b1;
            if (owner_req)
                state_nxt = owner_lock ? ARB_LOCKED : ARB_OWNED;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant    <= NUM_MASTERS'(1);
            hmaster   <= '0;
            hmastlock <= 1'b0;
            cnt       <= '0;
            rr        <= '0;
            state     <= ARB_PARK;
        end else if (hready) begin
            hgrant    <= grant_nxt;
            rr        <= rr_nxt;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hmaster   <= owner;
            hmastlock <= owner_lock;
        end
    end

endmodule
